// File: rtl/ysyx_22050133_lsu.sv
// Memory-access stage: registers one op from execute, issues an aligned 64-bit
// bus request for loads/stores, and hands the (extended) result to write-back.
module ysyx_22050133_lsu #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    mem_op,
    input  logic [1:0]    mem_size,
    input  logic          mem_unsigned,
    input  logic [63:0]   addr,
    input  logic [63:0]   wdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_data,
    output logic          out_fault,
    output logic          req_valid,
    input  logic          req_ready,
    output logic          req_wen,
    output logic [AW-1:0] req_addr,
    output logic [63:0]   req_wdata,
    output logic [7:0]    req_wmask,
    input  logic          resp_valid,
    input  logic [63:0]   resp_rdata,
    input  logic          resp_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    state_t        state, state_nxt;
    logic [1:0]    op_q, size_q;
    logic          uns_q;
    logic [AW-1:0] addr_q;
    logic [63:0]   wdata_q, out_data_q;
    logic          out_fault_q;

    logic          accept, is_mem_in, misaligned_in;
    logic [2:0]    off;
    logic [7:0]    size_mask;

    function automatic logic [63:0] extend(logic [63:0] v, logic [1:0] sz, logic uns);
        case (sz)
            2'b00:   return uns ? {56'b0, v[7:0]}  : {{56{v[7]}},  v[7:0]};
            2'b01:   return uns ? {48'b0, v[15:0]} : {{48{v[15]}}, v[15:0]};
            2'b10:   return uns ? {32'b0, v[31:0]} : {{32{v[31]}}, v[31:0]};
            default: return v;
        endcase
    endfunction

    assign accept    = in_valid && in_ready;
    assign is_mem_in = (mem_op == OP_LOAD) || (mem_op == OP_STORE);
    assign off       = addr_q[2:0];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        misaligned_in = 1'b0;
        case (mem_size)
            2'b01:   misaligned_in = addr[0];
            2'b10:   misaligned_in = |addr[1:0];
            2'b11:   misaligned_in = |addr[2:0];
            default: misaligned_in = 1'b0;
        endcase
    end

    always_comb begin
        size_mask = 8'h01;
        case (size_q)
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            2'b11:   size_mask = 8'hFF;
            default: size_mask = 8'h01;
        endcase
    end

    // NOTE: state and datapath registers use non-blocking assignments so all
    // flops update together at the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (is_mem_in && !misaligned_in) ? REQ : DONE;
            REQ:  if (req_ready) state_nxt = WAIT;
            WAIT: if (resp_valid) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        req_valid = (state == REQ);
        out_valid = (state == DONE);
    end

    // Non-memory and misaligned ops resolve at acceptance; bus ops resolve on the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            out_data_q  <= '0;
            out_fault_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= mem_op;
                size_q  <= mem_size;
                uns_q   <= mem_unsigned;
                addr_q  <= addr[AW-1:0];
                wdata_q <= wdata;
                if (!is_mem_in || misaligned_in) begin
                    out_data_q  <= addr;
                    out_fault_q <= is_mem_in && misaligned_in;
                end
            end
            if (state == WAIT && resp_valid) begin
                out_fault_q <= resp_err;
                out_data_q  <= (resp_err || op_q != OP_LOAD) ? 64'd0
                             : extend(resp_rdata >> {off, 3'b000}, size_q, uns_q);
            end
        end
    end

    assign req_wen   = (op_q == OP_STORE);
    assign req_addr  = {addr_q[AW-1:3], 3'b000};
    assign req_wdata = wdata_q << {off, 3'b000};
    assign req_wmask = req_wen ? (size_mask << off) : 8'h00;
    assign out_data  = out_data_q;
    assign out_fault = out_fault_q;

endmodule

// File: tb/tb_ysyx_22050133_lsu.sv
// Directed bench for the LSU: drives ops, plays the bus, and checks results
// through an expected-result queue popped at each write-back handshake.
module tb_ysyx_22050133_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [1:0]  mem_op, mem_size;
    logic        mem_unsigned;
    logic [63:0] addr, wdata;
    logic        out_valid, out_ready;
    logic [63:0] out_data;
    logic        out_fault;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;

    typedef struct packed {
        logic [63:0] data;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ysyx_22050133_lsu #(.AW(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem_op(mem_op), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .addr(addr), .wdata(wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_fault(out_fault),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one op at a negedge (accepted on the next posedge), serve the bus
    // if a request is expected, then complete write-back after out_hold stall cycles.
    task automatic run_op(string tag, logic [1:0] op, logic [1:0] sz, logic uns,
                          logic [63:0] a, logic [63:0] wd, logic [63:0] rdata,
                          logic err, int req_delay, int out_hold, logic exp_req,
                          logic [7:0] exp_wmask, logic [63:0] exp_wdata,
                          logic [63:0] exp_data, logic exp_fault);
        exp_t        e;
        logic [63:0] held;
        int          n;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; mem_op = op; mem_size = sz; mem_unsigned = uns;
        addr = a; wdata = wd;
        sb.push_back('{data: exp_data, fault: exp_fault});
        @(negedge clk);
        in_valid = 1'b0;
        if (exp_req) begin
            for (int i = 0; i <= req_delay; i++) begin
                chk({tag, ".req_valid"}, 64'(req_valid), 64'd1);
                chk({tag, ".req_addr"},  64'(req_addr), a & 64'h0000_0000_FFFF_FFF8);
                chk({tag, ".req_wen"},   64'(req_wen), 64'(op == 2'b10));
                chk({tag, ".req_wmask"}, 64'(req_wmask), 64'(exp_wmask));
                if (op == 2'b10) chk({tag, ".req_wdata"}, req_wdata, exp_wdata);
                if (i < req_delay) @(negedge clk);
            end
            req_ready = 1'b1;
            @(negedge clk);
            req_ready = 1'b0;
            chk({tag, ".req_drop"}, 64'(req_valid), 64'd0);
            resp_valid = 1'b1; resp_rdata = rdata; resp_err = err;
            @(negedge clk);
            resp_valid = 1'b0; resp_err = 1'b0;
        end else begin
            chk({tag, ".no_req"}, 64'(req_valid), 64'd0);
        end
        chk({tag, ".latency"}, 64'(out_valid), 64'd1);
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        held = out_data;
        for (int i = 0; i < out_hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
            chk({tag, ".hold_data"}, out_data, held);
        end
        e = sb.pop_front();
        chk({tag, ".out_data"},  out_data, e.data);
        chk({tag, ".out_fault"}, 64'(out_fault), 64'(e.fault));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".done_exit"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; mem_op = 2'b00; mem_size = 2'b00;
        mem_unsigned = 1'b0; addr = '0; wdata = '0; out_ready = 1'b0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0; resp_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.req_valid", 64'(req_valid), 64'd0);
        chk("rst.out_fault", 64'(out_fault), 64'd0);
        chk("rst.out_data",  out_data, 64'd0);
        chk("rst.req_wmask", 64'(req_wmask), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.in_ready", 64'(in_ready), 64'd1);

        // Stray bus handshakes while idle must not move the FSM.
        req_ready = 1'b1; resp_valid = 1'b1;
        @(negedge clk);
        req_ready = 1'b0; resp_valid = 1'b0;
        chk("idle_bus.req_valid", 64'(req_valid), 64'd0);
        chk("idle_bus.out_valid", 64'(out_valid), 64'd0);
        chk("idle_bus.in_ready",  64'(in_ready), 64'd1);

        run_op("nonmem", 2'b00, 2'b11, 1'b0, 64'h1234, 64'hFFFF, 64'h0, 1'b0, 0, 0, 1'b0,
               8'h00, 64'h0, 64'h1234, 1'b0);
        run_op("op11", 2'b11, 2'b00, 1'b0, 64'hCAFE_0000_0000_0001, 64'h0, 64'h0, 1'b0, 0, 0, 1'b0,
               8'h00, 64'h0, 64'hCAFE_0000_0000_0001, 1'b0);
        run_op("lb", 2'b01, 2'b00, 1'b0, 64'h8000_0005, 64'h0, 64'h0000_8000_0000_0000, 1'b0, 0, 0, 1'b1,
               8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        run_op("lhu", 2'b01, 2'b01, 1'b1, 64'h8000_0006, 64'h0, 64'hBEEF_0000_0000_0000, 1'b0, 0, 0, 1'b1,
               8'h00, 64'h0, 64'h0000_0000_0000_BEEF, 1'b0);
        run_op("lh", 2'b01, 2'b01, 1'b0, 64'h8000_0006, 64'h0, 64'hBEEF_0000_0000_0000, 1'b0, 0, 0, 1'b1,
               8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_BEEF, 1'b0);
        run_op("lw", 2'b01, 2'b10, 1'b0, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 1'b0, 1, 0, 1'b1,
               8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321, 1'b0);
        run_op("ld_uns", 2'b01, 2'b11, 1'b1, 64'h8000_0010, 64'h0, 64'h8000_0000_0000_0001, 1'b0, 0, 0, 1'b1,
               8'h00, 64'h0, 64'h8000_0000_0000_0001, 1'b0);
        run_op("sw", 2'b10, 2'b10, 1'b0, 64'h8000_0004, 64'hDEAD_BEEF, 64'h0, 1'b0, 3, 0, 1'b1,
               8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0, 1'b0);
        run_op("sb7", 2'b10, 2'b00, 1'b0, 64'h8000_0007, 64'h1122_3344_5566_77AB, 64'h0, 1'b0, 0, 0, 1'b1,
               8'h80, 64'hAB00_0000_0000_0000, 64'h0, 1'b0);
        run_op("sh2", 2'b10, 2'b01, 1'b0, 64'h8000_0002, 64'h0000_0000_0000_A55A, 64'h0, 1'b0, 0, 0, 1'b1,
               8'h0C, 64'h0000_0000_A55A_0000, 64'h0, 1'b0);
        run_op("ld_mis", 2'b01, 2'b11, 1'b0, 64'h8000_0004, 64'h0, 64'h0, 1'b0, 0, 0, 1'b0,
               8'h00, 64'h0, 64'h8000_0004, 1'b1);
        run_op("sh_mis", 2'b10, 2'b01, 1'b0, 64'h8000_0001, 64'h0, 64'h0, 1'b0, 0, 0, 1'b0,
               8'h00, 64'h0, 64'h8000_0001, 1'b1);
        run_op("ld_err", 2'b01, 2'b11, 1'b0, 64'h8000_0008, 64'h0, 64'h1234_5678_9ABC_DEF0, 1'b1, 0, 0, 1'b1,
               8'h00, 64'h0, 64'h0, 1'b1);
        run_op("stall", 2'b00, 2'b00, 1'b0, 64'h5555_AAAA, 64'h0, 64'h0, 1'b0, 0, 4, 1'b0,
               8'h00, 64'h0, 64'h5555_AAAA, 1'b0);

        // Reset while waiting for a response; the late response must be dropped.
        in_valid = 1'b1; mem_op = 2'b01; mem_size = 2'b11; mem_unsigned = 1'b0;
        addr = 64'h8000_0020;
        @(negedge clk);
        in_valid = 1'b0; req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        chk("rst_wait.in_wait", 64'(req_valid), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; resp_valid = 1'b1; resp_rdata = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        resp_valid = 1'b0;
        chk("rst_wait.out_valid", 64'(out_valid), 64'd0);
        chk("rst_wait.in_ready",  64'(in_ready), 64'd1);
        @(negedge clk);
        chk("rst_wait.out_valid2", 64'(out_valid), 64'd0);
        chk("rst_wait.out_data",   out_data, 64'd0);

        run_op("after_rst", 2'b00, 2'b00, 1'b0, 64'h77, 64'h0, 64'h0, 1'b0, 0, 0, 1'b0,
               8'h00, 64'h0, 64'h77, 1'b0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22050133_lsu.md
Name: ysyx_22050133_lsu

Overview:
- Memory-access stage directly downstream of the execute stage in the ysyx_22050133 RV64 pipeline.
- Consumes the execute-stage ALU result (used as the effective address) and the forwarded store data.
- Issues one aligned 64-bit request on a simple valid/ready data bus and waits for the response.
- Returns either the load value (shifted and extended), or the ALU result passed through for non-memory ops, to write-back via a valid/ready handshake.

Parameters:
- AW, 32, bus address width; upper address bits beyond AW are ignored.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  execute stage presents an op
- in_ready  output  1  LSU can accept an op
- mem_op  input  2  00 none, 01 load, 10 store, 11 treated as none
- mem_size  input  2  00 byte, 01 half, 10 word, 11 double
- mem_unsigned  input  1  zero-extend load (LBU/LHU/LWU)
- addr  input  64  execute result: effective address, or pass-through value
- wdata  input  64  store data (forwarded rs2)
- out_valid  output  1  result available to write-back
- out_ready  input  1  write-back consumes result
- out_data  output  64  load value, or addr for non-memory ops
- out_fault  output  1  misaligned access or bus error
- req_valid  output  1  bus request
- req_ready  input  1  bus accepts request
- req_wen  output  1  1 store, 0 load
- req_addr  output  AW  {addr[AW-1:3],3'b000}
- req_wdata  output  64  store data placed in byte lanes
- req_wmask  output  8  byte-lane write strobe; 0 for loads
- resp_valid  input  1  bus response; one per accepted request
- resp_rdata  input  64  aligned 64-bit read data
- resp_err  input  1  bus error, qualified by resp_valid

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset: state=IDLE. out_valid=0, req_valid=0, out_fault=0, out_data=0, req_wmask=0. All captured registers are cleared.
- in_ready=1 only in IDLE. An op is accepted when in_valid&&in_ready; op, size, unsigned flag, addr and wdata are registered at acceptance.
- Misalignment is checked on acceptance:
  - half: addr[0]!=0
  - word: addr[1:0]!=0
  - double: addr[2:0]!=0
- IDLE transitions on acceptance:
  - mem_op none/11 -> DONE, out_data=addr, out_fault=0.
  - misaligned load/store -> DONE, out_fault=1, out_data=addr, no bus request issued.
  - aligned load/store -> REQ.
- REQ: req_valid=1. req_addr, req_wen, req_wdata and req_wmask are held stable until req_ready. On req_valid&&req_ready -> WAIT; req_valid drops the next cycle.
- Store lanes:
  - off = addr[2:0].
  - req_wmask = (size mask 0x01/0x03/0x0F/0xFF) << off.
  - req_wdata = wdata << (8*off).
- WAIT: resp_valid is ignored outside WAIT.
  - On resp_valid -> DONE.
  - out_fault=resp_err.
  - Load: out_data = extend(resp_rdata >> (8*off), size, unsigned).
  - Store: out_data=0.
  - On resp_err, out_data=0.
- Load extension: byte/half/word are sign-extended from bit 7/15/31 unless mem_unsigned. Double ignores mem_unsigned.
- DONE: out_valid=1; out_data and out_fault are held stable until out_ready. On out_ready -> IDLE.
- No new op is accepted in the same cycle as the DONE handshake (in_ready is 0 in DONE).
- Latency from acceptance at cycle T:
  - non-memory or misaligned: out_valid at T+1.
  - aligned load/store with req_ready=1 and resp_valid one cycle after the request: req_valid at T+1, resp at T+2, out_valid at T+3.
- Reset mid-operation returns to IDLE immediately. Any outstanding response is dropped; a late resp_valid arriving in IDLE has no effect.
- req_ready asserted with req_valid=0 has no effect.
- Back-to-back ops: the next op is accepted in the cycle after the DONE handshake.

Test Plan:
- Non-memory op: mem_op=00, addr=0x1234 -> out_valid=1 at T+1, out_data=0x1234, out_fault=0, req_valid never asserted.
- Signed byte load: addr=0x80000005, size=00, unsigned=0, resp_rdata=0x0000_8000_0000_0000 -> req_addr=0x80000000, out_data=0xFFFF_FFFF_FFFF_FF80.
- Unsigned half load: addr=0x80000006, size=01, unsigned=1, resp_rdata=0xBEEF_0000_0000_0000 -> out_data=0xBEEF. Repeat with unsigned=0 -> 0xFFFF_FFFF_FFFF_BEEF.
- Word store: addr=0x80000004, size=10, wdata=0xDEADBEEF -> req_wen=1, req_wmask=0xF0, req_wdata=0xDEADBEEF_0000_0000. Hold req_ready=0 for 3 cycles -> request fields stable throughout.
- Misaligned double load: addr=0x80000004, size=11 -> no req_valid, out_fault=1, out_data=0x80000004. resp_err=1 on an aligned load -> out_fault=1, out_data=0.
- Reset in WAIT, then resp_valid=1 -> state IDLE, out_valid stays 0, in_ready=1. Hold out_ready=0 in DONE for 4 cycles -> out_data stable, in_ready=0.
